// File: rtl/pipe_pkg.sv
// Shared pipeline encodings and sizing helpers for the RV32 5-stage core.
package pipe_pkg;

  localparam int unsigned REG_AW_DEFAULT = 5;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10
  } res_src_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hazard_fwd_mux_sel.sv
// Per-operand forward select: M stage wins over W stage, x0 never forwards.
module hazard_fwd_mux_sel
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEFAULT
) (
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  output logic [1:0]        fwd_sel_c
);

  always_comb begin
    fwd_sel_c = FWD_RF;
    if (rs_e != '0) begin
      if (reg_write_m && (rs_e == rd_m)) begin
        fwd_sel_c = FWD_M;
      end else if (reg_write_w && (rs_e == rd_w)) begin
        fwd_sel_c = FWD_W;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: forwarding or interlock, load-use bubbles,
// multi-cycle execute stalls and taken-branch flushes.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW       = REG_AW_DEFAULT,
  parameter bit          FWD_EN       = 1'b1,
  parameter int unsigned LOAD_USE_CYC = 1,
  parameter int unsigned MC_LATENCY   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic              use_rs1_d,
  input  logic              use_rs2_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_e,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  input  logic [1:0]        result_src_e,
  input  logic              mc_op_e,
  input  logic              br_taken_e,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_m,
  output logic              mc_busy
);

  localparam int unsigned    LU_W    = 3;
  localparam int unsigned    MC_W    = cnt_width(MC_LATENCY);
  localparam logic [LU_W-1:0] LU_LOAD = LU_W'(LOAD_USE_CYC - 1);
  localparam logic [MC_W-1:0] MC_LAST = MC_W'(MC_LATENCY - 1);

  logic [LU_W-1:0] lu_cnt_q, lu_cnt_d;
  logic [MC_W-1:0] mc_cnt_q, mc_cnt_d;
  logic [1:0]      fwd_a_sel, fwd_b_sel;
  logic            lw_hz, raw_hz, rs1_hit, rs2_hit;
  logic            stall_lu, stall_mc;

  hazard_fwd_mux_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .rs_e        (rs1_e),
    .rd_m        (rd_m),
    .rd_w        (rd_w),
    .reg_write_m (reg_write_m),
    .reg_write_w (reg_write_w),
    .fwd_sel_c   (fwd_a_sel)
  );

  hazard_fwd_mux_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .rs_e        (rs2_e),
    .rd_m        (rd_m),
    .rd_w        (rd_w),
    .reg_write_m (reg_write_m),
    .reg_write_w (reg_write_w),
    .fwd_sel_c   (fwd_b_sel)
  );

  // Interlock sources: W is safe because the register file writes before it is read.
  assign rs1_hit = use_rs1_d && (rs1_d != '0) &&
                   ((reg_write_e && (rs1_d == rd_e)) || (reg_write_m && (rs1_d == rd_m)));
  assign rs2_hit = use_rs2_d && (rs2_d != '0) &&
                   ((reg_write_e && (rs2_d == rd_e)) || (reg_write_m && (rs2_d == rd_m)));
  assign raw_hz  = !FWD_EN && (rs1_hit || rs2_hit);

  assign lw_hz = (result_src_e == RES_LOAD) && reg_write_e && (rd_e != '0) &&
                 ((use_rs1_d && (rs1_d == rd_e)) || (use_rs2_d && (rs2_d == rd_e)));

  assign stall_lu = lw_hz || (lu_cnt_q != '0);
  assign stall_mc = mc_op_e && (mc_cnt_q != MC_LAST);

  // Priority: multi-cycle stall, then taken branch, then data hazards.
  always_comb begin
    fwd_a    = FWD_RF;
    fwd_b    = FWD_RF;
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    flush_m  = 1'b0;
    mc_busy  = 1'b0;
    lu_cnt_d = lu_cnt_q;
    mc_cnt_d = stall_mc ? (mc_cnt_q + MC_W'(1)) : '0;

    if (FWD_EN) begin
      fwd_a = fwd_a_sel;
      fwd_b = fwd_b_sel;
    end

    if (stall_mc) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      flush_m = 1'b1;
      mc_busy = 1'b1;
    end else if (br_taken_e) begin
      flush_d  = 1'b1;
      flush_e  = 1'b1;
      lu_cnt_d = '0;
    end else begin
      if (lu_cnt_q != '0) begin
        lu_cnt_d = lu_cnt_q - LU_W'(1);
      end else if (lw_hz) begin
        lu_cnt_d = LU_LOAD;
      end
      if (stall_lu || raw_hz) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end

    // Outputs are quiet for as long as reset is held.
    if (!rst_n) begin
      fwd_a   = FWD_RF;
      fwd_b   = FWD_RF;
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      flush_m = 1'b0;
      mc_busy = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_cnt_q <= '0;
      mc_cnt_q <= '0;
    end else begin
      lu_cnt_q <= lu_cnt_d;
      mc_cnt_q <= mc_cnt_d;
    end
  end

endmodule
